// File: rtl/mgnt_reg_hub.sv
// mgnt_reg_hub: SPI-to-management register hub.
//   SPI side : spi_wr/spi_op/spi_din write strobes into PTR, WDATA_LO and WDATA_HI;
//              spi_ack (comb copy of spi_wr), spi_busy, spi_dout (last result).
//   Mgmt side: sys_req_valid (one-hot device select), sys_req_wr, sys_req_addr (comb),
//              sys_req_data/_valid write beats MSB first; sys_req_ack and
//              sys_resp_data/_valid read bytes MSB first.
// Optional feature: define MGNT_REG_HUB_TIMEOUT_EN for per-request timeout supervision.
module mgnt_reg_hub #(
  parameter int unsigned NUM_DEV     = 7,
  parameter int unsigned REG_WIDTH   = 32,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [15:0] HUB_ID      = 16'h1235
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_wr,
  input  logic [6:0]         spi_op,
  input  logic [15:0]        spi_din,
  output logic               spi_ack,
  output logic               spi_busy,
  output logic [15:0]        spi_dout,
  output logic [NUM_DEV-1:0] sys_req_valid,
  output logic               sys_req_wr,
  output logic [7:0]         sys_req_addr,
  input  logic               sys_req_ack,
  output logic [7:0]         sys_req_data,
  output logic               sys_req_data_valid,
  input  logic [7:0]         sys_resp_data,
  input  logic               sys_resp_data_valid
);

  localparam int unsigned NBYTES = REG_WIDTH / 8;

  typedef enum logic [5:0] {
    S_IDLE     = 6'b000001,
    S_DECODE   = 6'b000010,
    S_XFER     = 6'b000100,
    S_WAIT_ACK = 6'b001000,
    S_LOCAL    = 6'b010000,
    S_DONE     = 6'b100000
  } state_t;

  state_t      state;
  logic [15:0] ptr;
  logic [15:0] wdata_lo;
  logic [15:0] wdata_hi;
  logic [31:0] rdata;
  logic [15:0] status;
  logic [15:0] status_nxt;
  logic [31:0] sh;
  logic [31:0] sh_init;
  logic [2:0]  bcnt;
  logic        ack_pend;
  logic        ack_now;
  logic [15:0] result;
  logic [15:0] loc_rd;
  logic        ptr_wr;
  logic        dev_ok;
  logic        dev_local;
  logic        expire;

  assign spi_ack      = spi_wr;
  assign sys_req_addr = ptr[7:0];
  assign ptr_wr       = spi_wr && (spi_op == 7'h00);
  assign dev_ok       = ptr[14:8] < 7'(NUM_DEV);
  assign dev_local    = ptr[14:8] == 7'h7F;
  assign ack_now      = sys_req_ack || ack_pend;
  // Write beats leave from the top byte of a left-shifting register.
  assign sh_init      = (REG_WIDTH == 32) ? {wdata_hi, wdata_lo} : {wdata_lo, 16'h0000};

`ifdef MGNT_REG_HUB_TIMEOUT_EN
  logic [31:0] tcnt;
  // An ack seen in WAIT_ACK on the expiry cycle completes normally.
  assign expire = ((state == S_XFER) || ((state == S_WAIT_ACK) && !ack_now)) &&
                  (tcnt == 32'(TIMEOUT_CYC));
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    loc_rd = '0;
    case (ptr[7:0])
      8'h00:   loc_rd = wdata_lo;
      8'h01:   loc_rd = (REG_WIDTH == 32) ? wdata_hi : '0;
      8'h02:   loc_rd = (REG_WIDTH == 32) ? rdata[31:16] : '0;
      8'h03:   loc_rd = status;
      8'h80:   loc_rd = HUB_ID;
      default: loc_rd = '0;
    endcase
  end

  always_comb begin
    status_nxt = status;
    if ((state == S_LOCAL) && ptr[15] && (ptr[7:0] == 8'h03))
      status_nxt = status & ~wdata_lo;
    if ((state == S_DECODE) && !dev_ok && !dev_local)
      status_nxt[15] = 1'b1;
    if (ptr_wr && (state != S_IDLE))
      status_nxt[14] = 1'b1;
`ifdef MGNT_REG_HUB_TIMEOUT_EN
    if (expire)
      status_nxt[NUM_DEV-1:0] = status_nxt[NUM_DEV-1:0] | sys_req_valid;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      ptr                <= '0;
      wdata_lo           <= '0;
      wdata_hi           <= '0;
      rdata              <= '0;
      status             <= '0;
      sh                 <= '0;
      bcnt               <= '0;
      ack_pend           <= 1'b0;
      result             <= '0;
      spi_busy           <= 1'b0;
      spi_dout           <= '0;
      sys_req_valid      <= '0;
      sys_req_wr         <= 1'b0;
      sys_req_data       <= '0;
      sys_req_data_valid <= 1'b0;
`ifdef MGNT_REG_HUB_TIMEOUT_EN
      tcnt               <= '0;
`endif
    end else begin
      if (spi_wr && (spi_op == 7'h01)) wdata_lo <= spi_din;
      if (spi_wr && (spi_op == 7'h02)) wdata_hi <= spi_din;
      status <= status_nxt;
`ifdef MGNT_REG_HUB_TIMEOUT_EN
      tcnt <= tcnt + 32'd1;
`endif
      case (state)
        S_IDLE: begin
          if (ptr_wr) begin
            ptr      <= spi_din;
            spi_busy <= 1'b1;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dev_ok) begin
            sys_req_valid <= NUM_DEV'(1) << ptr[14:8];
            sys_req_wr    <= ptr[15];
            ack_pend      <= 1'b0;
            bcnt          <= '0;
`ifdef MGNT_REG_HUB_TIMEOUT_EN
            tcnt          <= 32'd1;
`endif
            if (ptr[15]) begin
              sys_req_data       <= sh_init[31:24];
              sys_req_data_valid <= 1'b1;
              sh                 <= sh_init << 8;
              bcnt               <= 3'd1;
            end
            state <= S_XFER;
          end else if (dev_local) begin
            state <= S_LOCAL;
          end else begin
            result <= 16'hDEAD;
            state  <= S_DONE;
          end
        end
        S_XFER: begin
          if (sys_req_ack) ack_pend <= 1'b1;
          if (sys_req_wr) begin
            if (bcnt < 3'(NBYTES)) begin
              sys_req_data <= sh[31:24];
              sh           <= sh << 8;
              bcnt         <= bcnt + 3'd1;
            end else begin
              sys_req_data_valid <= 1'b0;
              state              <= S_WAIT_ACK;
            end
          end else begin
            if (bcnt == 3'(NBYTES)) begin
              state <= S_WAIT_ACK;
            end else if (sys_resp_data_valid) begin
              rdata <= {rdata[23:0], sys_resp_data};
              bcnt  <= bcnt + 3'd1;
            end
          end
        end
        S_WAIT_ACK: begin
          if (ack_now) begin
            sys_req_valid <= '0;
            sys_req_wr    <= 1'b0;
            ack_pend      <= 1'b0;
            result        <= sys_req_wr ? 16'h0000 : rdata[15:0];
            state         <= S_DONE;
          end
        end
        S_LOCAL: begin
          result <= loc_rd;
          state  <= S_DONE;
        end
        S_DONE: begin
          spi_dout <= result;
          spi_busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (expire) begin
        sys_req_valid      <= '0;
        sys_req_wr         <= 1'b0;
        sys_req_data_valid <= 1'b0;
        ack_pend           <= 1'b0;
        result             <= 16'hDEAD;
        state              <= S_DONE;
      end
    end
  end

endmodule

// File: tb/tb_mgnt_reg_hub.sv
module tb_mgnt_reg_hub;

  localparam int NB = 4;
  localparam logic [15:0] HUB = 16'h1235;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_wr;
  logic [6:0]  spi_op;
  logic [15:0] spi_din;
  logic        spi_ack;
  logic        spi_busy;
  logic [15:0] spi_dout;
  logic [6:0]  sys_req_valid;
  logic        sys_req_wr;
  logic [7:0]  sys_req_addr;
  logic        sys_req_ack;
  logic [7:0]  sys_req_data;
  logic        sys_req_data_valid;
  logic [7:0]  sys_resp_data;
  logic        sys_resp_data_valid;

  int checks = 0;
  int errors = 0;

  // reference model of the software-visible registers
  logic [15:0] m_wlo, m_whi, m_status;
  logic [31:0] m_rdata;

  mgnt_reg_hub #(
    .NUM_DEV(7),
    .REG_WIDTH(32),
    .TIMEOUT_CYC(16),
    .HUB_ID(16'h1235)
  ) dut (
    .clk(clk),
    .rst(rst),
    .spi_wr(spi_wr),
    .spi_op(spi_op),
    .spi_din(spi_din),
    .spi_ack(spi_ack),
    .spi_busy(spi_busy),
    .spi_dout(spi_dout),
    .sys_req_valid(sys_req_valid),
    .sys_req_wr(sys_req_wr),
    .sys_req_addr(sys_req_addr),
    .sys_req_ack(sys_req_ack),
    .sys_req_data(sys_req_data),
    .sys_req_data_valid(sys_req_data_valid),
    .sys_resp_data(sys_resp_data),
    .sys_resp_data_valid(sys_resp_data_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_local(input logic [7:0] a);
    case (a)
      8'h00:   return m_wlo;
      8'h01:   return m_whi;
      8'h02:   return m_rdata[31:16];
      8'h03:   return m_status;
      8'h80:   return HUB;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset;
    m_wlo = '0; m_whi = '0; m_status = '0; m_rdata = '0;
  endtask

  task automatic spi_write(input logic [6:0] op, input logic [15:0] d);
    spi_wr = 1'b1; spi_op = op; spi_din = d;
    #1;
    checks++;
    if (spi_ack !== 1'b1) begin
      errors++; $display("FAIL spi_ack got %b want 1", spi_ack);
    end
    tick;
    spi_wr = 1'b0;
    if (op == 7'h01) m_wlo = d;
    if (op == 7'h02) m_whi = d;
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({spi_dout, spi_busy, sys_req_valid, sys_req_wr, sys_req_data,
         sys_req_data_valid, sys_req_addr} !== '0) begin
      errors++;
      $display("FAIL %s outputs got dout=%h busy=%b valid=%h wr=%b data=%h dv=%b addr=%h want all 0",
               tag, spi_dout, spi_busy, sys_req_valid, sys_req_wr, sys_req_data,
               sys_req_data_valid, sys_req_addr);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; spi_wr = 0; spi_op = 0; spi_din = 0;
    sys_req_ack = 0; sys_resp_data = 0; sys_resp_data_valid = 0;
    tick; tick;
    rst = 1'b0;
    tick;
    model_reset();
    check_idle_outputs("reset");
  endtask

  task automatic test_local(input logic [7:0] a, input logic wr);
    logic [15:0] exp;
    exp = model_local(a);
    spi_wr = 1; spi_op = 7'h00; spi_din = {wr, 7'h7F, a};
    tick;
    spi_wr = 0;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (spi_busy !== (c < 4)) begin
        errors++; $display("FAIL local_busy c=%0d got %b want %b", c, spi_busy, c < 4);
      end
      checks++;
      if (sys_req_valid !== 7'h00) begin
        errors++; $display("FAIL local_valid c=%0d got %h want 00", c, sys_req_valid);
      end
      if (c == 4) begin
        checks++;
        if (spi_dout !== exp) begin
          errors++; $display("FAIL local_dout addr=%h got %h want %h", a, spi_dout, exp);
        end
      end else tick;
    end
    if (wr && a == 8'h03) m_status = m_status & ~m_wlo;
  endtask

  task automatic test_remote_write(input int dev, input logic [31:0] wd,
                                   input int ack_at, input int ovr_at);
    logic [6:0]  oh;
    logic [15:0] ptrv;
    int          td;
    logic        in_req;
    spi_write(7'h01, wd[15:0]);
    spi_write(7'h02, wd[31:16]);
    oh   = 7'(1) << dev;
    ptrv = {1'b1, 7'(dev), 8'($urandom)};
    td   = ((ack_at > NB + 2) ? ack_at : NB + 2) + 2;
    spi_wr = 1; spi_op = 7'h00; spi_din = ptrv;
    tick;
    spi_wr = 0;
    for (int c = 1; c <= td; c++) begin
      sys_req_ack = (c == ack_at);
      if (c == ovr_at) begin
        spi_wr = 1; spi_op = 7'h00; spi_din = 16'($urandom);
      end else spi_wr = 0;
      in_req = (c >= 2) && (c <= td - 2);
      checks++;
      if (sys_req_valid !== (in_req ? oh : 7'h00)) begin
        errors++; $display("FAIL wr_valid c=%0d got %h want %h", c, sys_req_valid, in_req ? oh : 7'h00);
      end
      checks++;
      if (sys_req_wr !== in_req) begin
        errors++; $display("FAIL wr_flag c=%0d got %b want %b", c, sys_req_wr, in_req);
      end
      checks++;
      if (sys_req_data_valid !== (c >= 2 && c <= NB + 1)) begin
        errors++; $display("FAIL wr_dv c=%0d got %b want %b", c, sys_req_data_valid, (c >= 2 && c <= NB + 1));
      end
      if (c >= 2 && c <= NB + 1) begin
        checks++;
        if (sys_req_data !== 8'(wd >> (8 * (NB + 1 - c)))) begin
          errors++; $display("FAIL wr_byte c=%0d got %h want %h", c, sys_req_data, 8'(wd >> (8 * (NB + 1 - c))));
        end
      end
      if (c == 2) begin
        checks++;
        if (sys_req_addr !== ptrv[7:0]) begin
          errors++; $display("FAIL wr_addr got %h want %h", sys_req_addr, ptrv[7:0]);
        end
      end
      checks++;
      if (spi_busy !== (c < td)) begin
        errors++; $display("FAIL wr_busy c=%0d got %b want %b", c, spi_busy, c < td);
      end
      if (c == td) begin
        checks++;
        if (spi_dout !== 16'h0000) begin
          errors++; $display("FAIL wr_dout got %h want 0000", spi_dout);
        end
      end else tick;
    end
    sys_req_ack = 0; spi_wr = 0;
    if (ovr_at > 0) m_status[14] = 1'b1;
  endtask

  task automatic test_remote_read(input int dev, input logic [31:0] bytes);
    logic [6:0] oh;
    int         arr[4];
    bit         done;
    oh = 7'(1) << dev;
    arr[0] = 2 + int'($urandom_range(0, 1));
    for (int i = 1; i < 4; i++) arr[i] = arr[i-1] + 1 + int'($urandom_range(0, 1));
    spi_wr = 1; spi_op = 7'h00; spi_din = {1'b0, 7'(dev), 8'($urandom)};
    tick;
    spi_wr = 0;
    done = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      // stray strobes in DECODE and after the last byte must be ignored
      sys_resp_data_valid = (c == 1) || (c == arr[3] + 1);
      sys_resp_data = 8'($urandom);
      for (int i = 0; i < 4; i++)
        if (c == arr[i]) begin
          sys_resp_data_valid = 1'b1;
          sys_resp_data = bytes[31 - 8 * i -: 8];
        end
      sys_req_ack = (c == arr[3] + 1);
      if (c >= 2 && c <= arr[3] + 1) begin
        checks++;
        if (sys_req_valid !== oh || sys_req_wr !== 1'b0) begin
          errors++; $display("FAIL rd_valid c=%0d got %h/%b want %h/0", c, sys_req_valid, sys_req_wr, oh);
        end
      end
      if (c > 1 && spi_busy === 1'b0) begin
        done = 1;
        checks++;
        if (spi_dout !== bytes[15:0]) begin
          errors++; $display("FAIL rd_dout got %h want %h", spi_dout, bytes[15:0]);
        end
        checks++;
        if (sys_req_valid !== 7'h00) begin
          errors++; $display("FAIL rd_valid_end got %h want 00", sys_req_valid);
        end
      end else tick;
    end
    sys_resp_data_valid = 0; sys_req_ack = 0;
    checks++;
    if (!done) begin
      errors++; $display("FAIL rd_timeout busy got %b want 0 within 40 cycles", spi_busy);
      tick;
    end
    m_rdata = bytes;
  endtask

  task automatic test_decode_err(input logic [15:0] ptrv);
    bit done;
    spi_wr = 1; spi_op = 7'h00; spi_din = ptrv;
    tick;
    spi_wr = 0;
    done = 0;
    for (int c = 1; c <= 10 && !done; c++) begin
      checks++;
      if (sys_req_valid !== 7'h00) begin
        errors++; $display("FAIL dec_valid c=%0d got %h want 00", c, sys_req_valid);
      end
      if (c > 1 && spi_busy === 1'b0) begin
        done = 1;
        checks++;
        if (spi_dout !== 16'hDEAD) begin
          errors++; $display("FAIL dec_dout got %h want dead", spi_dout);
        end
      end else tick;
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL dec_timeout busy got %b want 0", spi_busy);
      tick;
    end
    m_status[15] = 1'b1;
  endtask

`ifdef MGNT_REG_HUB_TIMEOUT_EN
  task automatic test_timeout;
    bit done;
    spi_wr = 1; spi_op = 7'h00; spi_din = {1'b0, 7'd1, 8'h10};
    tick;
    spi_wr = 0;
    done = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      if (c == 17 || c == 18) begin
        checks++;
        if (sys_req_valid !== ((c == 17) ? 7'h02 : 7'h00)) begin
          errors++; $display("FAIL to_valid c=%0d got %h want %h", c, sys_req_valid, (c == 17) ? 7'h02 : 7'h00);
        end
      end
      if (c > 1 && spi_busy === 1'b0) begin
        done = 1;
        checks++;
        if (spi_dout !== 16'hDEAD) begin
          errors++; $display("FAIL to_dout got %h want dead", spi_dout);
        end
      end else tick;
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL to_timeout busy got %b want 0", spi_busy);
      tick;
    end
    m_status[1] = 1'b1;
  endtask
`endif

  task automatic test_reset_mid;
    spi_wr = 1; spi_op = 7'h00; spi_din = {1'b1, 7'($urandom_range(0, 6)), 8'h55};
    tick;
    spi_wr = 0;
    tick; tick;          // now in cycle 3, transfer under way
    rst = 1'b1;
    tick;
    rst = 1'b0;
    model_reset();
    check_idle_outputs("reset_mid");
    test_local(8'h80, 1'b0);
    test_local(8'h03, 1'b0);
    test_local(8'h00, 1'b0);
  endtask

  initial begin
    test_reset();
    // local register space
    spi_write(7'h01, 16'($urandom));
    spi_write(7'h02, 16'($urandom));
    test_local(8'h00, 1'b0);
    test_local(8'h01, 1'b0);
    test_local(8'h80, 1'b0);
    test_local(8'h03, 1'b0);
    test_local(8'($urandom_range(4, 127)), 1'b0);
    // remote writes: directed then random
    test_remote_write(2, 32'hA1B2C3D4, 8, 0);
    test_remote_write(5, 32'($urandom), 3, 0);
    for (int i = 0; i < 4; i++)
      test_remote_write(int'($urandom_range(0, 6)), 32'($urandom), int'($urandom_range(2, 12)), 0);
    // remote reads
    test_remote_read(0, 32'h12345678);
    test_local(8'h02, 1'b0);
    for (int i = 0; i < 3; i++) begin
      test_remote_read(int'($urandom_range(0, 6)), 32'($urandom));
      test_local(8'h02, 1'b0);
    end
    // decode errors and write-1-to-clear
    test_decode_err(16'h4100);
    test_decode_err({1'($urandom), 7'($urandom_range(7, 126)), 8'($urandom)});
    test_local(8'h03, 1'b0);
    spi_write(7'h01, 16'h8000);
    test_local(8'h03, 1'b1);
    test_local(8'h03, 1'b0);
    // overrun during a write transfer
    test_remote_write(3, 32'($urandom), 9, 4);
    test_local(8'h03, 1'b0);
`ifdef MGNT_REG_HUB_TIMEOUT_EN
    test_timeout();
    test_local(8'h03, 1'b0);
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mgnt_reg_hub.md
# mgnt_reg_hub

Parametrised SPI-to-management register hub, successor to the single-width register controller. It takes 16-bit SPI register writes and turns them into byte-serial read/write transactions on a one-hot management bus to up to 14 remote devices. Per-device timeout supervision, sticky error status, an overrun guard and an explicit busy flag are added. It sits between the SPI slave front end and the port, switch and flow-table management endpoints.

## Interface
Parameters:
- NUM_DEV, 7: number of remote devices, legal range 1..14; device index = ptr[14:8].
- REG_WIDTH, 32: remote register width in bits, 16 or 32; NBYTES = REG_WIDTH/8.
- TIMEOUT_CYC, 1024: cycles allowed from request start to ack before abort; must be > NBYTES+2.
- HUB_ID, 16'h1235: constant returned by local address 0x80.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- spi_wr  in  1  one-cycle SPI register write strobe.
- spi_op  in  7  SPI register index: 0x00 PTR, 0x01 WDATA_LO, 0x02 WDATA_HI; other values are ignored.
- spi_din  in  16  SPI write data.
- spi_ack  out  1  combinational copy of spi_wr.
- spi_busy  out  1  high from the cycle after a PTR write until spi_dout is updated.
- spi_dout  out  16  result of the last PTR transaction.
- sys_req_valid  out  NUM_DEV  one-hot request select.
- sys_req_wr  out  1  1 = write, 0 = read; taken from ptr[15].
- sys_req_addr  out  8  ptr[7:0].
- sys_req_ack  in  1  transaction acknowledge from the selected device.
- sys_req_data  out  8  write data byte, MSB first.
- sys_req_data_valid  out  1  write byte strobe.
- sys_resp_data  in  8  read data byte, MSB first.
- sys_resp_data_valid  in  1  read byte strobe.

## Operation
- Registers: ptr[15:0], wdata[REG_WIDTH-1:0] (LO = bits 15:0, HI = bits 31:16, HI ignored when REG_WIDTH=16), rdata[REG_WIDTH-1:0], status[15:0].
- status layout: [15] decode_err, [14] overrun, [NUM_DEV-1:0] per-device timeout; all flags sticky.
- WDATA_LO/HI writes: accepted in any state, update wdata the next cycle.
- PTR write: accepted only in IDLE. A PTR write when not IDLE is dropped, sets overrun, and leaves the transaction in progress unaffected.
- FSM states, one-hot:
  - IDLE: PTR write latches ptr, goes to DECODE.
  - DECODE: ptr[14:8] < NUM_DEV goes to XFER; 7'h7F goes to LOCAL; anything else sets decode_err and goes to DONE with result 16'hDEAD.
  - XFER: sys_req_valid[idx] and sys_req_wr held. Write: NBYTES consecutive beats of wdata, MSB first, one per cycle with no stalls. Read: shift in sys_resp_data on each strobe, MSB first, until NBYTES bytes are counted. Then goes to WAIT_ACK.
  - WAIT_ACK: sys_req_ack high clears valid/wr next cycle and goes to DONE. An ack that arrives during XFER is held pending and is consumed on entry to WAIT_ACK.
  - LOCAL: read ptr[7:0]: 0x00 wdata LO, 0x01 wdata HI, 0x02 rdata[31:16] (0 when REG_WIDTH=16), 0x03 status, 0x80 HUB_ID, other addresses 0. Write (ptr[15]=1) to 0x03: status &= ~wdata[15:0] (write-1-to-clear); result is status before the clear. Then goes to DONE.
  - DONE: loads spi_dout (remote read: rdata[15:0]; remote write: 0); spi_busy falls; goes to IDLE.
- Response bytes beyond NBYTES, and any response outside XFER, are ignored.
- Reset: all state cleared, FSM to IDLE. Reset mid-transaction aborts it without setting flags.
- Reset values: spi_dout 0, spi_busy 0, sys_req_valid 0, sys_req_wr 0, sys_req_data 0, sys_req_data_valid 0, sys_req_addr 0, status 0.

## Timing
- A PTR write in cycle 0: DECODE in cycle 1; sys_req_valid and the first write beat appear in cycle 2.
- Remote write: beats in cycles 2..NBYTES+1; if ack is already high, spi_dout updates at cycle NBYTES+4.
- Local access: spi_dout updates and spi_busy falls at cycle 4.
- All outputs registered except spi_ack and sys_req_addr.

## Configuration
- MGNT_REG_HUB_TIMEOUT_EN defined: a counter runs in XFER/WAIT_ACK. When it reaches TIMEOUT_CYC it drops valid/wr/data_valid, sets status[idx], sets the result to 16'hDEAD and goes to DONE. An ack in the same cycle as expiry wins.
- MGNT_REG_HUB_TIMEOUT_EN undefined: no counter; the hub waits for ack indefinitely and status[NUM_DEV-1:0] reads 0.

## Test plan
- Remote write, dev 2, REG_WIDTH=32, wdata=0xA1B2C3D4, ack at cycle 8 -> valid=0x04; bytes A1,B2,C3,D4 in cycles 2..5; spi_dout=0 at cycle 10.
- Remote read, dev 0, responses 0x12,0x34,0x56,0x78 with gaps -> spi_dout=0x5678; local read of 0x02 -> 0x1234.
- PTR to 0x4100 -> decode_err set, spi_dout=0xDEAD, no valid asserted; local W1C of 0x03 with wdata 0x8000 clears it.
- PTR write while busy -> transaction unchanged, status[14]=1.
- TIMEOUT_EN with TIMEOUT_CYC=16, no ack from dev 1 -> valid drops at cycle 18, status[1]=1, spi_dout=0xDEAD.
- rst pulse during XFER -> all outputs at reset values next cycle; a new PTR write is accepted.
